mccoy_ctrl_seq: RTL

MCCOY_CTRL_SEQ -- requirements
Module: mccoy_ctrl_seq

---
 rtl/mccoy_pkg.sv | 32 +++
 rtl/mccoy_ctrl_seq_if.sv | 38 +++
 rtl/mccoy_dec_table.sv | 47 ++++
 rtl/mccoy_ctrl_seq.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/mccoy_pkg.sv
// Shared definitions for the mccoy control sequencer: opcode encodings,
// sequencer states and the registered control-word layout.
package mccoy_pkg;

  localparam logic [2:0] OP_BEZ  = 3'd0;
  localparam logic [2:0] OP_LI   = 3'd1;
  localparam logic [2:0] OP_JA   = 3'd2;
  localparam logic [2:0] OP_ADD  = 3'd3;
  localparam logic [2:0] OP_LR   = 3'd4;
  localparam logic [2:0] OP_NOT  = 3'd5;
  localparam logic [2:0] OP_SR   = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  typedef struct packed {
    logic       bez;
    logic       ja;
    logic       op1;
    logic [1:0] op2;
    logic       alu_fun;
    logic       write_reg;
    logic       write_x8;
    logic [1:0] x8_sel;
  } ctrl_word_t;

endpackage

// File: rtl/mccoy_ctrl_seq_if.sv
// Instruction handshake plus control-word bundle of the mccoy sequencer.
// slave = sequencer side, master = instruction source / control consumer.
interface mccoy_ctrl_seq_if #(
  parameter int OPW  = 3,
  parameter int IMMW = 5
);
  logic                  instr_valid;
  logic                  instr_ready;
  logic [OPW+IMMW-1:0]   instr;
  logic                  stall;
  logic                  zero_flag;
  logic                  resume;
  logic                  ctrl_valid;
  logic                  bez;
  logic                  ja;
  logic                  op1;
  logic [1:0]            op2;
  logic                  alu_fun;
  logic                  write_reg;
  logic                  write_x8;
  logic [1:0]            x8_sel;
  logic [IMMW-1:0]       imm;
  logic                  branch_taken;
  logic                  illegal;
  logic                  halted;

  modport slave (
    input  instr_valid, instr, stall, zero_flag, resume,
    output instr_ready, ctrl_valid, bez, ja, op1, op2, alu_fun,
           write_reg, write_x8, x8_sel, imm, branch_taken, illegal, halted
  );

  modport master (
    output instr_valid, instr, stall, zero_flag, resume,
    input  instr_ready, ctrl_valid, bez, ja, op1, op2, alu_fun,
           write_reg, write_x8, x8_sel, imm, branch_taken, illegal, halted
  );
endinterface

// File: rtl/mccoy_dec_table.sv
// Opcode-to-control-word table. Opcodes beyond the 3-bit range decode to an
// all-zero word and raise illegal.
module mccoy_dec_table
  import mccoy_pkg::*;
#(
  parameter int OPW = 3
) (
  input  logic [OPW-1:0] opcode,
  output ctrl_word_t     cw,
  output logic           illegal
);

  logic hi_bits;

  if (OPW > 3) begin : g_hi
    assign hi_bits = |opcode[OPW-1:3];
  end else begin : g_nohi
    assign hi_bits = 1'b0;
  end

  // table lookup, everything defaults to zero
  always_comb begin
    cw      = '0;
    illegal = 1'b0;
    if (hi_bits) begin
      illegal = 1'b1;
    end else begin
      unique case (opcode[2:0])
        OP_BEZ:  begin cw.bez = 1'b1; cw.op2 = 2'd1; end
        OP_LI:   begin cw.write_x8 = 1'b1; cw.x8_sel = 2'd1; end
        OP_JA:   begin cw.ja = 1'b1; cw.op1 = 1'b1; cw.op2 = 2'd1; end
        OP_ADD:  cw.write_x8 = 1'b1;
        OP_LR:   cw.write_x8 = 1'b1;
        OP_NOT:  begin
          cw.op1      = 1'b1;
          cw.alu_fun  = 1'b1;
          cw.write_x8 = 1'b1;
          cw.x8_sel   = 2'd2;
        end
        OP_SR:   cw.write_reg = 1'b1;
        OP_HALT: cw = '0;
        default: cw = '0;
      endcase
    end
  end

endmodule

// File: rtl/mccoy_ctrl_seq.sv
// Single-issue control sequencer: accepts one instruction at a time, presents
// its registered control word one cycle later, and handles branch flush and
// halt. Outside ISSUE the control word and immediate are held at zero.
module mccoy_ctrl_seq
  import mccoy_pkg::*;
#(
  parameter int OPW  = 3,
  parameter int IMMW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  mccoy_ctrl_seq_if.slave bus
);

  state_e          state_q, state_d;
  ctrl_word_t      ctrl_q, ctrl_d;
  logic [IMMW-1:0] imm_q, imm_d;
  logic [2:0]      op_q, op_d;
  logic            ill_q, ill_d;
  logic            first_q, first_d;

  logic [OPW-1:0]  opcode_in;
  ctrl_word_t      dec_cw;
  logic            dec_ill;
  logic            is_ja, is_bez, is_halt;
  logic            instr_ready;
  logic            branch_taken;
  logic            illegal_p;

  assign opcode_in = bus.instr[OPW+IMMW-1 -: OPW];

  mccoy_dec_table #(.OPW(OPW)) u_dec (
    .opcode  (opcode_in),
    .cw      (dec_cw),
    .illegal (dec_ill)
  );

  // illegal words reuse low opcode bits, so they must not alias ja/bez/halt
  assign is_ja   = !ill_q && (op_q == OP_JA);
  assign is_bez  = !ill_q && (op_q == OP_BEZ);
  assign is_halt = !ill_q && (op_q == OP_HALT);

  // Ready depends only on state, the latched opcode and stall. A bez that
  // turns out taken may still have accepted the next word; that word is the
  // wrong-path fetch and is squashed by the flush.
  always_comb begin
    instr_ready = 1'b0;
    unique case (state_q)
      ST_IDLE:  instr_ready = 1'b1;
      ST_ISSUE: instr_ready = !bus.stall && !is_ja && !is_halt;
      default:  instr_ready = 1'b0;
    endcase
  end

  // next-state, control-word load/clear and single-cycle pulses
  always_comb begin
    state_d      = state_q;
    ctrl_d       = ctrl_q;
    imm_d        = imm_q;
    op_d         = op_q;
    ill_d        = ill_q;
    first_d      = 1'b0;
    branch_taken = 1'b0;
    illegal_p    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.instr_valid) begin
          state_d = ST_ISSUE;
          ctrl_d  = dec_cw;
          imm_d   = bus.instr[IMMW-1:0];
          op_d    = opcode_in[2:0];
          ill_d   = dec_ill;
          first_d = 1'b1;
        end
      end
      ST_ISSUE: begin
        illegal_p = first_q && ill_q;
        if (!bus.stall) begin
          if (is_ja || (is_bez && bus.zero_flag)) begin
            branch_taken = 1'b1;
            state_d      = ST_FLUSH;
            ctrl_d       = '0;
            imm_d        = '0;
            ill_d        = 1'b0;
          end else if (is_halt) begin
            state_d = ST_HALT;
            ctrl_d  = '0;
            imm_d   = '0;
            ill_d   = 1'b0;
          end else if (bus.instr_valid) begin
            ctrl_d  = dec_cw;
            imm_d   = bus.instr[IMMW-1:0];
            op_d    = opcode_in[2:0];
            ill_d   = dec_ill;
            first_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
            ctrl_d  = '0;
            imm_d   = '0;
            ill_d   = 1'b0;
          end
        end
      end
      ST_FLUSH: state_d = ST_IDLE;
      ST_HALT: begin
        if (bus.resume) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state and control-word registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ctrl_q  <= '0;
      imm_q   <= '0;
      op_q    <= '0;
      ill_q   <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      imm_q   <= imm_d;
      op_q    <= op_d;
      ill_q   <= ill_d;
      first_q <= first_d;
    end
  end

  assign bus.instr_ready  = instr_ready;
  assign bus.ctrl_valid   = (state_q == ST_ISSUE);
  assign bus.halted       = (state_q == ST_HALT);
  assign bus.branch_taken = branch_taken;
  assign bus.illegal      = illegal_p;
  assign bus.bez          = ctrl_q.bez;
  assign bus.ja           = ctrl_q.ja;
  assign bus.op1          = ctrl_q.op1;
  assign bus.op2          = ctrl_q.op2;
  assign bus.alu_fun      = ctrl_q.alu_fun;
  assign bus.write_reg    = ctrl_q.write_reg;
  assign bus.write_x8     = ctrl_q.write_x8;
  assign bus.x8_sel       = ctrl_q.x8_sel;
  assign bus.imm          = imm_q;

endmodule
